// File: rtl/ifq.sv
// Instruction fetch queue: issues one synchronous I-mem read per accepted PC and buffers
// {pc, inst} pairs for decode, with a single outstanding read and a flush/redirect input.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ifq #(
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_flush,
   output logic                  o_mem_en,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ADDR_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_inst
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];

   logic      push, wr, pop;
   logic [CW:0] used;

   // The outstanding read holds a reserved slot so its data can never be dropped.
   assign used     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign o_ready  = i_rst_n && !i_flush && (used < (CW+1)'(DEPTH));
   assign push     = i_valid && o_ready;
   assign wr       = inflight_q && !i_flush;
   assign o_valid  = (count_q != '0) && !i_flush;
   assign pop      = o_valid && i_ready;

   assign o_mem_en   = push;
   assign o_mem_addr = i_pc;
   assign o_pc       = pc_mem_q[rptr_q];
   assign o_inst     = inst_mem_q[rptr_q];

   always_comb begin
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      inflight_d = push;
      pend_pc_d  = push ? i_pc : pend_pc_q;
      if (i_flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (wr) begin
            wptr_d = wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PW'(1);
         end
         case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         inflight_q <= 1'b0;
         pend_pc_q  <= '0;
      end else begin
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         inflight_q <= inflight_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   // Read data is captured the cycle it arrives, so memory need not hold it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else if (wr) begin
         pc_mem_q[wptr_q]   <= pend_pc_q;
         inst_mem_q[wptr_q] <= i_mem_data;
      end
   end

endmodule

// File: doc/ifq.md
IFQ -- requirements
Module: ifq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (32): PC/address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  PC request valid from the fetch PC generator.
REQ-007 SHALL have port o_ready  output  1  queue can accept a PC request.
REQ-008 SHALL have port i_pc  input  ADDR_WIDTH  requested fetch PC.
REQ-009 SHALL have port i_flush  input  1  redirect; discard everything queued and in flight.
REQ-010 SHALL have port o_mem_en  output  1  synchronous instruction-memory read enable.
REQ-011 SHALL have port o_mem_addr  output  ADDR_WIDTH  instruction-memory read address.
REQ-012 SHALL have port i_mem_data  input  DATA_WIDTH  read data, valid exactly one cycle after o_mem_en.
REQ-013 SHALL have port o_valid  output  1  instruction available to decode.
REQ-014 SHALL have port i_ready  input  1  decode accepts the instruction.
REQ-015 SHALL have port o_pc  output  ADDR_WIDTH  PC of the head instruction.
REQ-016 SHALL have port o_inst  output  DATA_WIDTH  head instruction word.

Function
REQ-017 SHALL accept a request (push request) when i_valid && o_ready && !i_flush.
REQ-018 SHALL drive o_ready = i_rst_n && !i_flush && (count + inflight) < DEPTH.
- count: occupied entries, width clog2(DEPTH)+1.
- inflight: 1-bit, read outstanding.
REQ-019 SHALL drive o_mem_en = push request and o_mem_addr = i_pc, both combinational, in the accept cycle.
REQ-020 SHALL, on an accept, set inflight and capture i_pc into a pending-PC register at the edge ending the accept cycle.
REQ-021 SHALL, in the cycle after an accept, write {pending PC, i_mem_data} into the entry at the write pointer at the closing edge, without requiring memory data to be held.
REQ-022 SHALL clear inflight at that write edge unless a new accept happens in the same cycle.
REQ-023 SHALL give an accept-to-o_valid latency of exactly 2 edges; back-to-back accepts with i_ready held high SHALL sustain one instruction per cycle.
REQ-024 SHALL drive o_valid = (count != 0) && !i_flush; o_pc and o_inst SHALL be read from the entry at the read pointer.
REQ-025 SHALL pop when o_valid && i_ready, advancing the read pointer modulo DEPTH.
REQ-026 SHALL hold o_pc and o_inst stable while o_valid && !i_ready.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL leave count unchanged on a simultaneous write and pop; a write alone increments count and a pop alone decrements it.
REQ-029 SHALL make count never exceed DEPTH, guaranteed by the reservation in REQ-018; no write is ever dropped while not flushing.
REQ-030 SHALL, when i_flush is high, force o_ready=0, o_mem_en=0 and o_valid=0.
REQ-031 SHALL, at the edge ending a flush cycle:
- set count=0 and both pointers=0;
- clear inflight, so any outstanding read data is discarded and never written.
REQ-032 SHALL make the flush cycle's pop and write ineffective; a request may be accepted in the cycle after the flush.
REQ-033 SHALL make a flush with nothing queued or in flight a no-op apart from REQ-030.

Reset
REQ-034 SHALL, on i_rst_n low, asynchronously clear count, pointers, inflight, pending PC and all entry storage to 0.
REQ-035 SHALL, while in reset, drive o_valid=0, o_ready=0, o_mem_en=0, o_pc=0 and o_inst=0.
REQ-036 SHALL, after deassertion, drive o_ready=1 in the first cycle; a reset asserted mid-operation SHALL discard all queued and in-flight data.

Verification
REQ-037 SHALL pass single fetch: i_valid with i_pc=0x80000000, mem returns 0x00000013 next cycle -> o_valid two edges after accept with o_pc=0x80000000, o_inst=0x00000013.
REQ-038 SHALL pass streaming: PCs 0x0,0x4,0x8,0xC accepted on consecutive cycles, i_ready=1 -> o_valid high 4 consecutive cycles, in order, no bubbles.
REQ-039 SHALL pass backpressure: i_ready=0, continuous i_valid -> exactly 4 accepts, then o_ready=0; head stays 0x0; raising i_ready drains in order and o_ready returns to 1.
REQ-040 SHALL pass flush with a read in flight: accept 0x10, then pulse i_flush in the next cycle -> o_valid never shows 0x10; accept of 0x100 in the following cycle yields o_pc=0x100.
REQ-041 SHALL pass wrap: 10 fetches with i_ready toggling every cycle -> output order matches accept order across pointer wrap, count never exceeds 4.
REQ-042 SHALL pass async reset mid-stream: i_rst_n low between edges with 3 entries queued -> o_valid=0 immediately; after release o_ready=1 and no stale output appears.
